// File: rtl/multdiv_div_issue.sv
// multdiv_div_issue: issues one divide at a time to an external divider and holds the result for writeback.
//   clock, reset_n                 : clock and asynchronous active-low reset
//   start_div, opA, opB, dest_reg  : divide request from execute (dividend, divisor, destination tag)
//   div_operandA/B, ctrl_DIV       : latched operands and one-cycle start pulse to the divider
//   div_result/exception/resultRDY : divider response
//   stall                          : busy; pipeline holds the execute stage
//   wb_valid/data/reg/exception    : result held for writeback until wb_ack
module multdiv_div_issue #(
  parameter int TIMEOUT = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start_div,
  input  logic [31:0] opA,
  input  logic [15:0] opB,
  input  logic [4:0]  dest_reg,
  output logic [31:0] div_operandA,
  output logic [15:0] div_operandB,
  output logic        ctrl_DIV,
  input  logic [31:0] div_result,
  input  logic        div_exception,
  input  logic        div_resultRDY,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_reg,
  output logic        wb_exception,
  input  logic        wb_ack
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_opa, r_wb_data;
  logic [15:0]     r_opb;
  logic [4:0]      r_wb_reg;
  logic            r_wb_exc;
  logic            w_accept, w_zero, w_tmo;
  assign w_accept = r_state == IDLE && start_div;
  assign w_zero   = opB == 16'd0;
  assign w_tmo    = r_cnt == CW'(TIMEOUT - 1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start_div ? (w_zero ? DONE : ISSUE) : IDLE;
      ISSUE:   w_next = WAIT;
      WAIT:    w_next = (div_resultRDY || w_tmo) ? DONE : WAIT;
      DONE:    w_next = wb_ack ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_wb_data <= '0;
      r_wb_reg  <= '0;
      r_wb_exc  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wb_reg  <= dest_reg;
        r_wb_data <= '0;
        r_wb_exc  <= w_zero;
        if (!w_zero) begin
          r_opa <= opA;
          r_opb <= opB;
        end
      end
      if (r_state == ISSUE) r_cnt <= '0;
      if (r_state == WAIT) begin
        r_cnt <= r_cnt + 1'b1;
        // a result arriving on the timeout cycle wins over the timeout
        if (div_resultRDY) begin
          r_wb_data <= div_result;
          r_wb_exc  <= div_exception;
        end else if (w_tmo) begin
          r_wb_data <= '0;
          r_wb_exc  <= 1'b1;
        end
      end
    end
  end
  assign div_operandA = r_opa;
  assign div_operandB = r_opb;
  assign ctrl_DIV     = r_state == ISSUE;
  assign stall        = r_state != IDLE;
  assign wb_valid     = r_state == DONE;
  assign wb_data      = r_wb_data;
  assign wb_reg       = r_wb_reg;
  assign wb_exception = r_wb_exc;
endmodule

// File: tb/tb_multdiv_div_issue.sv
// tb_multdiv_div_issue: directed self-checking bench for multdiv_div_issue.
module tb_multdiv_div_issue;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_div = 1'b0;
  logic [31:0] opA = '0;
  logic [15:0] opB = '0;
  logic [4:0]  dest_reg = '0;
  logic [31:0] div_operandA;
  logic [15:0] div_operandB;
  logic        ctrl_DIV;
  logic [31:0] div_result = '0;
  logic        div_exception = 1'b0;
  logic        div_resultRDY = 1'b0;
  logic        stall, wb_valid, wb_exception;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg;
  logic        wb_ack = 1'b0;
  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int base;
  multdiv_div_issue #(.TIMEOUT(8)) dut (
    .clock(clock), .reset_n(reset_n), .start_div(start_div), .opA(opA), .opB(opB),
    .dest_reg(dest_reg), .div_operandA(div_operandA), .div_operandB(div_operandB),
    .ctrl_DIV(ctrl_DIV), .div_result(div_result), .div_exception(div_exception),
    .div_resultRDY(div_resultRDY), .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_reg(wb_reg), .wb_exception(wb_exception), .wb_ack(wb_ack)
  );
  always #5 clock = ~clock;
  always @(posedge clock) if (ctrl_DIV === 1'b1) pulses++;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_stall"}, 32'(stall), 0);
    chk({tag, "_valid"}, 32'(wb_valid), 0);
    chk({tag, "_ctrl"}, 32'(ctrl_DIV), 0);
    chk({tag, "_data"}, wb_data, 0);
    chk({tag, "_reg"}, 32'(wb_reg), 0);
    chk({tag, "_exc"}, 32'(wb_exception), 0);
    chk({tag, "_opa"}, div_operandA, 0);
    chk({tag, "_opb"}, 32'(div_operandB), 0);
  endtask
  task automatic req(input logic [31:0] a, input logic [15:0] b, input logic [4:0] d);
    start_div = 1'b1; opA = a; opB = b; dest_reg = d;
    tick();
    start_div = 1'b0;
  endtask
  task automatic ack();
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
  endtask
  initial begin
    tick(); tick();
    chk_reset("reset");
    reset_n = 1'b1;
    // normal divide, result two cycles after ctrl_DIV
    base = pulses;
    req(32'd100, 16'd7, 5'd3);
    chk("norm_ctrl", 32'(ctrl_DIV), 1);
    chk("norm_stall", 32'(stall), 1);
    chk("norm_opa", div_operandA, 100);
    chk("norm_opb", 32'(div_operandB), 7);
    tick();
    chk("norm_ctrl_low", 32'(ctrl_DIV), 0);
    tick();
    div_resultRDY = 1'b1; div_result = 32'd14;
    tick();
    div_resultRDY = 1'b0;
    chk("norm_valid", 32'(wb_valid), 1);
    chk("norm_data", wb_data, 14);
    chk("norm_reg", 32'(wb_reg), 3);
    chk("norm_exc", 32'(wb_exception), 0);
    chk("norm_pulses", 32'(pulses - base), 1);
    ack();
    chk("norm_stall_drop", 32'(stall), 0);
    chk("norm_valid_drop", 32'(wb_valid), 0);
    // signed divide, best-case latency, held through 3 cycles without ack
    req(32'hFFFFFF9C, 16'd7, 5'd12);
    tick();
    div_resultRDY = 1'b1; div_result = 32'hFFFFFFF2;
    tick();
    chk("sgn_valid_lat3", 32'(wb_valid), 1);
    chk("sgn_data", wb_data, 32'hFFFFFFF2);
    div_result = 32'h0BADBEEF;
    start_div = 1'b1; opA = 32'd5; opB = 16'd1; dest_reg = 5'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sgn_hold_data", wb_data, 32'hFFFFFFF2);
      chk("sgn_hold_valid", 32'(wb_valid), 1);
    end
    start_div = 1'b0; div_resultRDY = 1'b0;
    chk("sgn_hold_reg", 32'(wb_reg), 12);
    chk("sgn_hold_opa", div_operandA, 32'hFFFFFF9C);
    ack();
    // zero divisor, back-to-back in the cycle after ack
    base = pulses;
    req(32'd55, 16'd0, 5'd9);
    chk("zero_valid", 32'(wb_valid), 1);
    chk("zero_exc", 32'(wb_exception), 1);
    chk("zero_data", wb_data, 0);
    chk("zero_reg", 32'(wb_reg), 9);
    chk("zero_ctrl", 32'(ctrl_DIV), 0);
    chk("zero_opa_kept", div_operandA, 32'hFFFFFF9C);
    ack();
    chk("zero_no_pulse", 32'(pulses - base), 0);
    // timeout after 8 WAIT cycles
    req(32'd1000, 16'd3, 5'd7);
    for (int i = 0; i < 8; i++) tick();
    chk("tmo_not_yet", 32'(wb_valid), 0);
    tick();
    chk("tmo_valid", 32'(wb_valid), 1);
    chk("tmo_exc", 32'(wb_exception), 1);
    chk("tmo_data", wb_data, 0);
    chk("tmo_reg", 32'(wb_reg), 7);
    ack();
    // result on the timeout cycle wins
    req(32'd1000, 16'd3, 5'd8);
    for (int i = 0; i < 8; i++) tick();
    div_resultRDY = 1'b1; div_result = 32'h1234;
    tick();
    div_resultRDY = 1'b0;
    chk("prio_valid", 32'(wb_valid), 1);
    chk("prio_data", wb_data, 32'h1234);
    chk("prio_exc", 32'(wb_exception), 0);
    ack();
    // second request during WAIT is ignored
    base = pulses;
    req(32'd200, 16'd9, 5'd4);
    tick();
    start_div = 1'b1; opA = 32'd5; opB = 16'd1; dest_reg = 5'd1;
    tick();
    start_div = 1'b0;
    chk("busy_opa", div_operandA, 200);
    chk("busy_opb", 32'(div_operandB), 9);
    div_resultRDY = 1'b1; div_result = 32'd22;
    tick();
    div_resultRDY = 1'b0;
    chk("busy_data", wb_data, 22);
    chk("busy_reg", 32'(wb_reg), 4);
    ack();
    tick(); tick();
    chk("busy_single_valid", 32'(wb_valid), 0);
    chk("busy_single_pulse", 32'(pulses - base), 1);
    // reset while in WAIT
    req(32'd300, 16'd5, 5'd6);
    tick();
    #2 reset_n = 1'b0;
    #1 chk_reset("rstwait");
    tick();
    reset_n = 1'b1;
    div_resultRDY = 1'b1; div_result = 32'd60;
    tick(); tick();
    div_resultRDY = 1'b0;
    chk("rstwait_no_valid", 32'(wb_valid), 0);
    chk("rstwait_idle", 32'(stall), 0);
    // first request after reset release is taken on the first edge
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    req(32'd40, 16'd4, 5'd2);
    chk("post_rst_ctrl", 32'(ctrl_DIV), 1);
    chk("post_rst_opa", div_operandA, 40);
    tick();
    div_resultRDY = 1'b1; div_result = 32'd10;
    tick();
    div_resultRDY = 1'b0;
    chk("post_rst_data", wb_data, 10);
    ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multdiv_div_issue.md
MULTDIV_DIV_ISSUE -- requirements
Module: multdiv_div_issue

Interface
REQ-001 Parameter TIMEOUT, default 8: maximum cycles in WAIT before a forced timeout exception.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start_div  input  1  one-cycle request from execute stage to begin a divide.
REQ-005 opA  input  32  dividend, signed two's complement.
REQ-006 opB  input  16  divisor, signed two's complement.
REQ-007 dest_reg  input  5  destination register tag travelling with the request.
REQ-008 div_operandA  output  32  latched dividend driven to the divider.
REQ-009 div_operandB  output  16  latched divisor driven to the divider.
REQ-010 ctrl_DIV  output  1  one-cycle start pulse to the divider.
REQ-011 div_result  input  32  quotient from the divider.
REQ-012 div_exception  input  1  divide-by-zero flag from the divider.
REQ-013 div_resultRDY  input  1  divider result-valid strobe.
REQ-014 stall  output  1  high while a divide occupies the block; the pipeline holds the execute stage.
REQ-015 wb_valid  output  1  completed result available for writeback.
REQ-016 wb_data  output  32  captured quotient.
REQ-017 wb_reg  output  5  captured destination tag.
REQ-018 wb_exception  output  1  divide-by-zero or timeout flag for this result.
REQ-019 wb_ack  input  1  writeback stage has consumed the result.

Function
REQ-020 The block SHALL implement states IDLE, ISSUE, WAIT and DONE, encoded in a 2-bit state register.
REQ-021 In IDLE, when start_div=1 and opB!=0: latch opA, opB and dest_reg; go to ISSUE.
REQ-022 In IDLE, when start_div=1 and opB==0: latch dest_reg; set wb_data=0 and wb_exception=1; go to DONE; ctrl_DIV is never pulsed.
REQ-023 ISSUE lasts exactly one cycle: ctrl_DIV=1, cycle counter cleared to 0, next state WAIT.
REQ-024 div_operandA and div_operandB SHALL hold the latched values constant from ISSUE through DONE.
REQ-025 In WAIT, the counter increments by 1 per cycle.
REQ-026 In WAIT, div_resultRDY=1: capture div_result into wb_data and div_exception into wb_exception on that edge; go to DONE.
REQ-027 In WAIT, counter reaching TIMEOUT-1 with div_resultRDY=0: set wb_data=0 and wb_exception=1; go to DONE.
REQ-028 If div_resultRDY and timeout coincide, div_resultRDY SHALL take priority.
REQ-029 div_resultRDY SHALL be ignored in IDLE, ISSUE and DONE.
REQ-030 In DONE, wb_valid=1 and wb_data, wb_reg and wb_exception SHALL be held stable until wb_ack=1; wb_ack=1 in DONE returns the block to IDLE on that edge.
REQ-031 wb_ack SHALL be ignored outside DONE.
REQ-032 stall SHALL equal 1 in ISSUE, WAIT and DONE and 0 in IDLE; it is registered state decode, with no combinational path from start_div.
REQ-033 start_div while stall=1 SHALL be ignored; it is neither queued nor allowed to alter latched operands.
REQ-034 Best-case latency from the start_div edge to wb_valid=1 is 3 cycles (ISSUE, WAIT with div_resultRDY, DONE); a zero-divisor request reaches DONE after 1 cycle.
REQ-035 Back-to-back operation: start_div may be accepted in the cycle after wb_ack, once the block is in IDLE.

Reset
REQ-036 reset_n=0 SHALL immediately force: state=IDLE, counter=0, ctrl_DIV=0, stall=0, wb_valid=0, wb_exception=0, wb_data=0, wb_reg=0, div_operandA=0, div_operandB=0.
REQ-037 Reset asserted mid-operation, in any state, SHALL abandon the divide without emitting wb_valid.
REQ-038 After reset_n rises, the first start_div SHALL be accepted on the first rising clock edge.

Verification
REQ-039 Normal divide: opA=100, opB=7, dest_reg=3, divider returns div_result=14 two cycles after ctrl_DIV -> one ctrl_DIV pulse; wb_valid=1 with wb_data=14, wb_reg=3, wb_exception=0; stall drops the cycle after wb_ack.
REQ-040 Signed divide: opA=-100 (0xFFFFFF9C), opB=7, div_result=0xFFFFFFF2 -> wb_data=0xFFFFFFF2 held through 3 cycles of wb_ack=0.
REQ-041 Zero divisor: opB=0 -> ctrl_DIV stays 0; DONE on the next edge with wb_exception=1 and wb_data=0.
REQ-042 Timeout: div_resultRDY tied to 0, TIMEOUT=8 -> DONE after 8 WAIT cycles with wb_exception=1.
REQ-043 Busy rejection: second start_div with opA=5 issued during WAIT -> div_operandA unchanged and a single result produced.
REQ-044 Reset in WAIT: reset_n pulsed low -> all outputs reach reset values immediately and no wb_valid follows.
